// File: rtl/uart_tx.sv
// uart_tx: buffered asynchronous serial transmitter, 8 data bits, LSB first,
// one stop bit. Bytes are queued in a FIFO_DEPTH-entry circular buffer and
// sent back to back with no idle gap while the buffer holds data.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> 8E1 frame (even parity bit after the data bits, 11 bit periods)
//   undefined -> 8N1 frame (10 bit periods), no parity state or logic
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   baud_tick    one-clk pulse per bit period
//   tx_data      byte to enqueue
//   tx_data_en   one-clk write strobe qualifying tx_data
//   tx           registered serial line, idle high
//   tx_busy      frame in flight or buffer non-empty
//   tx_fifo_full buffer holds FIFO_DEPTH bytes
//   tx_overflow  sticky flag: a write was dropped because the buffer was full
module uart_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_data_en,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_fifo_full,
    output logic       tx_overflow
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
    } state_t;
`endif

    state_t          state;
    state_t          state_next;

    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;

    logic [7:0]      shift_reg;
    logic [7:0]      shift_next;
    logic [2:0]      bit_idx;
    logic            tx_next;
`ifdef UART_TX_PARITY_EN
    logic            parity_bit;
    logic            parity_next;
`endif

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);

    // A frame boundary (IDLE or the closing tick of STOP) is the only place
    // a byte leaves the buffer.
    assign pop  = baud_tick && !fifo_empty && (state == IDLE || state == STOP);
    // A full buffer still accepts a write when a pop frees a slot that cycle.
    assign push = tx_data_en && (!fifo_full || pop);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: every transition is qualified by baud_tick
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pop) state_next = START;
            end
            START: begin
                if (baud_tick) state_next = DATA;
            end
            DATA: begin
                if (baud_tick && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) state_next = STOP;
            end
`endif
            STOP: begin
                if (baud_tick) state_next = pop ? START : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: tx is computed for the state being entered so the
    // registered line changes on the same edge as the state.
    always_comb begin
        shift_next = shift_reg;
        if (pop) begin
            shift_next = fifo_mem[rd_ptr];
        end else if (state == DATA && baud_tick) begin
            shift_next = {1'b0, shift_reg[7:1]};
        end

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_bit;
`endif
            default: tx_next = 1'b1;
        endcase
    end

`ifdef UART_TX_PARITY_EN
    // Even parity is captured when the byte is popped, before shifting
    // destroys the data bits.
    always_comb begin
        parity_next = parity_bit;
        if (pop) parity_next = ^fifo_mem[rd_ptr];
    end
`endif

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
            bit_idx     <= 3'd0;
            tx          <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (tx_data_en && fifo_full && !pop) tx_overflow <= 1'b1;
            // Wraps 7 -> 0 on the last data tick, ready for the next frame
            if (state == DATA && baud_tick) bit_idx <= bit_idx + 1'b1;
            tx <= tx_next;
        end
    end

    // Data registers: meaningless until loaded, so left unreset
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= tx_data;
        shift_reg <= shift_next;
`ifdef UART_TX_PARITY_EN
        parity_bit <= parity_next;
`endif
    end

    assign tx_busy      = (state != IDLE) || !fifo_empty;
    assign tx_fifo_full = fifo_full;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus pushes expected bytes into a queue,
// a line monitor decodes frames off tx and pops/compares each one.
module tb_uart_tx;

    localparam int BD    = 8;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic [7:0] tx_data;
    logic       tx_data_en;
    logic       tx;
    logic       tx_busy;
    logic       tx_fifo_full;
    logic       tx_overflow;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] sb[$];
    int         start_cyc[$];
    int         frames_done = 0;
    int         mcyc = 0;
`ifdef UART_TX_PARITY_EN
    logic       par_log[$];
`endif

    uart_tx #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_tick    (baud_tick),
        .tx_data      (tx_data),
        .tx_data_en   (tx_data_en),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_fifo_full (tx_fifo_full),
        .tx_overflow  (tx_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick: one clock in every BD, changed just after the rising edge
    initial begin : tick_gen
        int div;
        div = 0;
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div = (div == BD - 1) ? 0 : div + 1;
            baud_tick = (div == 0);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Line monitor: samples each bit mid-period, relative to the start edge
    task automatic monitor_loop();
        int         ph;
        int         k;
        logic       active;
        logic [7:0] sh;
        logic [7:0] exp_b;
`ifdef UART_TX_PARITY_EN
        logic       par;
        par = 1'b0;
`endif
        active = 1'b0;
        ph = 0;
        sh = '0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (rst) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    ph = 0;
                    start_cyc.push_back(mcyc);
                end
            end else begin
                ph++;
                if (ph % BD == BD / 2) begin
                    k = ph / BD;
                    if (k == 0) begin
                        check("start_bit", tx, 1'b0);
                    end else if (k <= 8) begin
                        sh[k-1] = tx;
                    end else if (k == FRAME_BITS - 1) begin
                        check("stop_bit", tx, 1'b1);
                        active = 1'b0;
                        frames_done++;
                        if (sb.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_frame: got %0h expected no frame", sh);
                        end else begin
                            exp_b = sb.pop_front();
                            check("frame_byte", sh, exp_b);
`ifdef UART_TX_PARITY_EN
                            check("parity_bit", par, ^exp_b);
                            par_log.push_back(par);
`endif
                        end
                    end else begin
`ifdef UART_TX_PARITY_EN
                        par = tx;
`endif
                    end
                end
            end
        end
    endtask

    task automatic write_one(input logic [7:0] d);
        tx_data = d;
        tx_data_en = 1'b1;
        sb.push_back(d);
        @(negedge clk);
        tx_data_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n;
        n = 0;
        while (tx_busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(nm, tx_busy, 1'b0);
    endtask

    task automatic wait_tx_low(input int budget, input string nm);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(nm, tx, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
    endtask

    initial begin : stim
        int f0;
        int s0;
        int n;
        int guard;
        logic [7:0] bb [3];
        bb = '{8'hA5, 8'h3C, 8'hFF};

        fork
            monitor_loop();
        join_none

        rst = 1'b1;
        tx_data = 8'h00;
        tx_data_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", tx_busy, 1'b0);
        check("reset_full", tx_fifo_full, 1'b0);
        check("reset_ovf", tx_overflow, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0x55
        f0 = frames_done;
        write_one(8'h55);
        wait_idle(3 * FRAME_BITS * BD, "single_busy_fall");
        check("single_frames", frames_done - f0, 1);
        check("single_tx_idle", tx, 1'b1);
        check("single_sb_empty", sb.size(), 0);

        // Back-to-back 0xA5, 0x3C, 0xFF
        f0 = frames_done;
        s0 = start_cyc.size();
        for (int i = 0; i < 3; i++) begin
            tx_data = bb[i];
            tx_data_en = 1'b1;
            sb.push_back(bb[i]);
            @(negedge clk);
        end
        tx_data_en = 1'b0;
        wait_idle(5 * FRAME_BITS * BD, "b2b_busy_fall");
        check("b2b_frames_before_idle", frames_done - f0, 3);
        check("b2b_start_count", start_cyc.size() - s0, 3);
        if (start_cyc.size() >= s0 + 3) begin
            check("b2b_gap1", start_cyc[s0+1] - start_cyc[s0], FRAME_BITS * BD);
            check("b2b_gap2", start_cyc[s0+2] - start_cyc[s0+1], FRAME_BITS * BD);
        end

        // Overflow: 0x01 popped, 0x02..0x05 buffered, 0x06 dropped
        do_reset();
        f0 = frames_done;
        write_one(8'h01);
        wait_tx_low(2 * BD, "ovf_first_start");
        for (int i = 2; i <= 5; i++) begin
            tx_data = 8'(i);
            tx_data_en = 1'b1;
            sb.push_back(8'(i));
            @(negedge clk);
        end
        check("ovf_full_before", tx_fifo_full, 1'b1);
        check("ovf_clear_before", tx_overflow, 1'b0);
        tx_data = 8'h06;
        tx_data_en = 1'b1;
        @(negedge clk);
        tx_data_en = 1'b0;
        check("ovf_set", tx_overflow, 1'b1);
        wait_idle(7 * FRAME_BITS * BD, "ovf_busy_fall");
        check("ovf_frames", frames_done - f0, 5);
        check("ovf_sticky", tx_overflow, 1'b1);
        check("ovf_sb_empty", sb.size(), 0);

        // Full FIFO, write on the pop cycle
        do_reset();
        check("post_reset_ovf", tx_overflow, 1'b0);
        f0 = frames_done;
        write_one(8'h10);
        wait_tx_low(2 * BD, "sim_first_start");
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (baud_tick) n++;
            tx_data = 8'h11 + 8'(i);
            tx_data_en = 1'b1;
            sb.push_back(8'h11 + 8'(i));
            @(negedge clk);
        end
        tx_data_en = 1'b0;
        check("sim_full", tx_fifo_full, 1'b1);
        guard = 0;
        while (guard < 2 * FRAME_BITS * BD) begin
            if (baud_tick) begin
                n++;
                if (n == FRAME_BITS) break;
            end
            @(negedge clk);
            guard++;
        end
        check("sim_align", n, FRAME_BITS);
        tx_data = 8'h15;
        tx_data_en = 1'b1;
        sb.push_back(8'h15);
        @(negedge clk);
        tx_data_en = 1'b0;
        check("sim_still_full", tx_fifo_full, 1'b1);
        check("sim_no_ovf", tx_overflow, 1'b0);
        wait_idle(8 * FRAME_BITS * BD, "sim_busy_fall");
        check("sim_frames", frames_done - f0, 6);
        check("sim_sb_empty", sb.size(), 0);
        check("sim_ovf_end", tx_overflow, 1'b0);

        // Reset mid-frame of 0xC3, write during reset ignored, then 0x81
        do_reset();
        write_one(8'hC3);
        wait_tx_low(2 * BD, "rst_first_start");
        n = 0;
        guard = 0;
        while (n < 5 && guard < 8 * BD) begin
            if (baud_tick) n++;
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check("rst_mid_busy", tx_busy, 1'b1);
        rst = 1'b1;
        tx_data = 8'hEE;
        tx_data_en = 1'b1;
        sb.delete();
        @(negedge clk);
        check("rst_mid_tx", tx, 1'b1);
        check("rst_mid_busy_low", tx_busy, 1'b0);
        check("rst_mid_full", tx_fifo_full, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tx_data_en = 1'b0;
        @(negedge clk);
        check("rst_write_ignored", tx_busy, 1'b0);
        f0 = frames_done;
        write_one(8'h81);
        wait_idle(3 * FRAME_BITS * BD, "rst_new_busy_fall");
        check("rst_new_frames", frames_done - f0, 1);
        check("rst_sb_empty", sb.size(), 0);

`ifdef UART_TX_PARITY_EN
        // Parity: 0x07 -> 1, 0x03 -> 0
        do_reset();
        par_log.delete();
        f0 = frames_done;
        write_one(8'h07);
        write_one(8'h03);
        wait_idle(4 * FRAME_BITS * BD, "par_busy_fall");
        check("par_frames", frames_done - f0, 2);
        if (par_log.size() == 2) begin
            check("par_07", par_log[0], 1'b1);
            check("par_03", par_log[1], 1'b0);
        end else begin
            check("par_log_size", par_log.size(), 2);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning number of byte entries in the input buffer (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port baud_tick  input  1  one-clk pulse per bit period, from baud_tick_gen.
REQ-005 SHALL have port tx_data  input  8  byte to transmit, from cmd_respond_tlb.
REQ-006 SHALL have port tx_data_en  input  1  one-clk write strobe qualifying tx_data.
REQ-007 SHALL have port tx  output  1  serial line, idle high.
REQ-008 SHALL have port tx_busy  output  1  high while a frame is in flight or the buffer is non-empty.
REQ-009 SHALL have port tx_fifo_full  output  1  buffer holds FIFO_DEPTH bytes.
REQ-010 SHALL have port tx_overflow  output  1  sticky; a write was dropped.

Function
REQ-011 SHALL buffer bytes in a FIFO_DEPTH-entry circular FIFO; write when tx_data_en=1 and not full; pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-012 SHALL drop tx_data_en writes while full and not popping that cycle, and set tx_overflow=1 until reset.
REQ-013 SHALL accept a write on a full FIFO in the same cycle as a pop; count unchanged, no overflow.
REQ-014 SHALL use states IDLE, START, DATA, PARITY, STOP; all transitions occur only on cycles with baud_tick=1.
REQ-015 IDLE: on baud_tick with FIFO non-empty, pop head into shift register, go START; tx=0 from the next clk.
REQ-016 START -> DATA on baud_tick; DATA shifts LSB first, one bit per baud_tick, bit index counter 0..7.
REQ-017 DATA after bit 7 -> PARITY when parity is compiled in, otherwise -> STOP.
REQ-018 STOP drives tx=1 for one bit period; on its closing baud_tick, if FIFO non-empty pop and go START directly (no idle gap), else IDLE.
REQ-019 SHALL register tx (no combinational path from inputs to tx); each bit held exactly one baud_tick interval.
REQ-020 tx_busy = (state != IDLE) or (count != 0), registered or combinational from registers only.
REQ-021 SHALL ignore baud_tick while IDLE and FIFO empty; a write and baud_tick in the same cycle on an empty FIFO starts the frame on the next baud_tick.
REQ-022 tx_data_en while a frame is in flight SHALL enqueue only; the shifting byte is never altered.

Reset
REQ-023 On rst=1: state=IDLE, tx=1, FIFO pointers and count=0, bit counter=0, tx_busy=0, tx_fifo_full=0, tx_overflow=0.
REQ-024 Reset mid-frame SHALL abort the frame and discard buffered bytes; tx=1 on the clk after reset is sampled.
REQ-025 tx_data_en and baud_tick during reset SHALL be ignored.

Configuration
REQ-026 Macro UART_TX_PARITY_EN: when defined, PARITY state transmits even parity (XOR of 8 data bits) for one bit period, frame 8E1 (11 bit periods).
REQ-027 Without UART_TX_PARITY_EN, PARITY state and its logic SHALL be absent; frame 8N1 (10 bit periods).

Verification
REQ-028 Single byte: write 0x55 in IDLE -> tx bits 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), one per baud_tick; tx_busy falls after stop.
REQ-029 Back-to-back: write 0xA5,0x3C,0xFF in consecutive clks -> three frames with no idle gap between stop and next start; tx_busy continuous.
REQ-030 Overflow: FIFO_DEPTH=4, write 6 bytes 0x01..0x06 while first frame starts -> 0x01..0x05 transmitted (one popped plus four buffered), 0x06 dropped, tx_overflow=1 sticky.
REQ-031 Parity (UART_TX_PARITY_EN): write 0x07 -> parity bit 1; write 0x03 -> parity bit 0; frame 11 bit periods.
REQ-032 Reset mid-frame: assert rst after bit 3 of 0xC3 -> tx=1, tx_busy=0, count=0 next clk; new write 0x81 transmits cleanly.
REQ-033 Simultaneous full write/pop: full FIFO, tx_data_en on the pop cycle -> byte accepted, no overflow, all bytes transmitted in order.
